// File: rtl/l0_act_loader_if.sv
// l0_act_loader_if
//   Bundles the activation-SRAM read port and the L0 row-buffer port seen by
//   l0_act_loader.
//   master : the loader (drives SRAM controls and L0 strobes/data)
//   slave  : the SRAM/L0 side (returns read data and L0 full)
//   Signals: sram_cen, sram_wen, sram_addr, sram_q, l0_in, l0_wr, l0_full, l0_rd
interface l0_act_loader_if #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11
);
    logic                  sram_cen;
    logic                  sram_wen;
    logic [addr_w-1:0]     sram_addr;
    logic [row*bw-1:0]     sram_q;
    logic [row*bw-1:0]     l0_in;
    logic                  l0_wr;
    logic                  l0_full;
    logic                  l0_rd;

    modport master (
        output sram_cen, sram_wen, sram_addr, l0_in, l0_wr, l0_rd,
        input  sram_q, l0_full
    );

    modport slave (
        input  sram_cen, sram_wen, sram_addr, l0_in, l0_wr, l0_rd,
        output sram_q, l0_full
    );
endinterface

// File: rtl/l0_act_loader.sv
// l0_act_loader
//   Fetches len consecutive activation words from SRAM into the L0 row buffer
//   (stalling on L0 full), then issues len L0 read requests and waits out the
//   L0 per-row read stagger before pulsing done.
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   base_addr, len    first SRAM address and vector count, sampled with start
//   busy              high in every non-IDLE state
//   done              one-cycle pulse at end of operation
//   bus (master)      SRAM read port and L0 write/read port
// Configuration
//   L0_LOADER_OVERLAP_EN : when defined, L0 reads start while the fetch is still
//   running (one read per committed write); otherwise strict load-then-drain.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// FETCH | reading SRAM and writing L0 (also reading L0 when overlapped)
// DRAIN | issuing the len L0 read requests
// WAIT  | row cycles for the L0 row stagger to play out
// DONE  | one-cycle done pulse
module l0_act_loader #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11,
    parameter int len_w  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [len_w-1:0]  len,
    output logic              busy,
    output logic              done,
    l0_act_loader_if.master   bus
);
    localparam int wait_w = $clog2(row + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [addr_w-1:0] base_r;
    logic [len_w-1:0]  len_r;
    logic [len_w-1:0]  issued;
    logic [len_w-1:0]  wr_count;
    logic [len_w-1:0]  rd_count;
    logic [wait_w-1:0] wait_cnt;
    logic              q_vld;

    // Registered cen leaves two words in flight when L0 goes full, so the
    // skid holds up to two; new reads are only issued with the skid empty.
    logic [1:0]        skid_cnt;
    logic [row*bw-1:0] skid0, skid1;
    logic [1:0]        skid_cnt_pop;
    logic              skid_pop, skid_push;

    logic              issue;
    logic [addr_w-1:0] issue_addr;

    assign bus.sram_wen = 1'b1;

    always_comb begin
        issue      = 1'b0;
        issue_addr = base_r + addr_w'(issued);
        if (state_q == IDLE) begin
            issue      = start && (len != '0) && !bus.l0_full;
            issue_addr = base_addr;
        end else if (state_q == FETCH) begin
            issue = (issued < len_r) && !bus.l0_full && (skid_cnt == 2'd0);
        end
    end

    // Skid words are older than the word on sram_q, so they go first.
    always_comb begin
        bus.l0_wr = 1'b0;
        bus.l0_in = '0;
        if (!bus.l0_full) begin
            if (skid_cnt != 2'd0) begin
                bus.l0_wr = 1'b1;
                bus.l0_in = skid0;
            end else if (q_vld) begin
                bus.l0_wr = 1'b1;
                bus.l0_in = bus.sram_q;
            end
        end
    end

    assign skid_pop     = bus.l0_wr && (skid_cnt != 2'd0);
    assign skid_push    = q_vld && !(bus.l0_wr && (skid_cnt == 2'd0));
    assign skid_cnt_pop = skid_cnt - {1'b0, skid_pop};

    always_comb begin
        state_d    = state_q;
        bus.l0_rd  = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len == '0) ? DONE : FETCH;
            end
            FETCH: begin
`ifdef L0_LOADER_OVERLAP_EN
                bus.l0_rd = (rd_count < wr_count) && (rd_count < len_r);
                if (rd_count + len_w'(bus.l0_rd) == len_r) state_d = WAIT;
`else
                if (wr_count + len_w'(bus.l0_wr) == len_r) state_d = DRAIN;
`endif
            end
            DRAIN: begin
                bus.l0_rd = 1'b1;
                if (rd_count == len_r - len_w'(1)) state_d = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bus.sram_cen  <= 1'b1;
            bus.sram_addr <= '0;
            q_vld         <= 1'b0;
            base_r        <= '0;
            len_r         <= '0;
            issued        <= '0;
            wr_count      <= '0;
            rd_count      <= '0;
            wait_cnt      <= '0;
            skid_cnt      <= 2'd0;
            skid0         <= '0;
            skid1         <= '0;
        end else begin
            state_q      <= state_d;
            bus.sram_cen <= !issue;
            if (issue) bus.sram_addr <= issue_addr;
            q_vld <= !bus.sram_cen;

            if (state_q == IDLE) begin
                if (start) begin
                    base_r <= base_addr;
                    len_r  <= len;
                end
                issued   <= len_w'(issue);
                wr_count <= '0;
                rd_count <= '0;
            end else begin
                issued   <= issued + len_w'(issue);
                wr_count <= wr_count + len_w'(bus.l0_wr);
                rd_count <= rd_count + len_w'(bus.l0_rd);
            end

            // Down-counter: loaded outside WAIT, terminal count 0 ends WAIT.
            if (state_q != WAIT) wait_cnt <= wait_w'(row - 1);
            else if (wait_cnt != '0) wait_cnt <= wait_cnt - wait_w'(1);

            if (skid_pop) skid0 <= skid1;
            if (skid_push) begin
                if (skid_cnt_pop == 2'd0) skid0 <= bus.sram_q;
                else                      skid1 <= bus.sram_q;
            end
            skid_cnt <= skid_cnt_pop + {1'b0, skid_push};
        end
    end
endmodule

// File: tb/tb_l0_act_loader.sv
module tb_l0_act_loader;
    localparam int ROW  = 8;
    localparam int BW   = 4;
    localparam int AW   = 11;
    localparam int LW   = 7;
    localparam int DW   = ROW * BW;
    localparam int MAXC = 2000;
`ifdef L0_LOADER_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy, done;
    logic          full_drv;
    logic [DW-1:0] q_reg = '0;
    logic [DW-1:0] mem [0:2047];

    int n_vec = 0;
    int n_err = 0;

    l0_act_loader_if #(.row(ROW), .bw(BW), .addr_w(AW)) bus ();

    l0_act_loader #(.row(ROW), .bw(BW), .addr_w(AW), .len_w(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .len(len), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // SRAM model: data for the address presented with cen low appears next cycle.
    always @(posedge clk) if (bus.sram_cen === 1'b0) q_reg <= mem[bus.sram_addr];
    assign bus.sram_q  = q_reg;
    assign bus.l0_full = full_drv;

    // Observations of one operation, cycle 0 = cycle start is high.
    logic [AW-1:0] o_addr[$];
    logic [DW-1:0] o_data[$];
    int o_first_cen, o_first_wr, o_last_wr, o_first_rd, o_last_rd, o_rd_n;
    int o_done_cyc, o_done_n, o_busy_bad, o_wr_full, o_rd_rule;
    bit o_timeout;

    function automatic bit full_at(input int mode, input int lo, input int hi, input int c);
        if (mode == 1) return (c >= lo) && (c <= hi);
        if (mode == 2) return $urandom_range(99) < lo;
        return 1'b0;
    endfunction

    function automatic int exp_done(input int n);
        return OVL ? n + 3 + ROW : 2 * n + 2 + ROW;
    endfunction

    task automatic run_op(input logic [AW-1:0] b, input logic [LW-1:0] n,
                          input int fmode, input int flo, input int fhi, input bit noise);
        int c, ni, wr_before, rd_before;
        bit exp_rd, exp_busy;
        ni = int'(n);
        o_addr.delete(); o_data.delete();
        o_first_cen = -1; o_first_wr = -1; o_last_wr = -1; o_first_rd = -1; o_last_rd = -1;
        o_rd_n = 0; o_done_cyc = -1; o_done_n = 0; o_busy_bad = 0; o_wr_full = 0;
        o_rd_rule = 0; o_timeout = 1'b0;
        wr_before = 0; rd_before = 0; c = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n;
        full_drv = full_at(fmode, flo, fhi, 0);
        forever begin
            @(negedge clk);
            if (bus.sram_cen === 1'b0) begin
                o_addr.push_back(bus.sram_addr);
                if (o_first_cen < 0) o_first_cen = c;
            end
            // L0 may be read only once all words are in (or, overlapped,
            // once a committed write is ahead of the reads), never beyond len.
            if (OVL) exp_rd = (rd_before < wr_before) && (rd_before < ni);
            else     exp_rd = (wr_before == ni) && (rd_before < ni);
            if (bus.l0_rd !== exp_rd) o_rd_rule++;
            if (bus.l0_wr === 1'b1) begin
                if (full_drv) o_wr_full++;
                o_data.push_back(bus.l0_in);
                if (o_first_wr < 0) o_first_wr = c;
                o_last_wr = c;
                wr_before++;
            end
            if (bus.l0_rd === 1'b1) begin
                if (o_first_rd < 0) o_first_rd = c;
                o_last_rd = c;
                rd_before++;
                o_rd_n++;
            end
            if (done === 1'b1) begin
                o_done_n++;
                if (o_done_cyc < 0) o_done_cyc = c;
            end
            exp_busy = (c >= 1) && ((o_done_cyc < 0) || (o_done_cyc == c));
            if (busy !== exp_busy) o_busy_bad++;
            if (o_done_cyc >= 0 && c > o_done_cyc) break;
            if (c >= MAXC) begin o_timeout = 1'b1; break; end
            @(posedge clk); #1;
            c++;
            start = noise && (ni > 0) && (c <= ni + ROW) && ($urandom_range(1) == 1);
            if (noise) begin base_addr = AW'($urandom); len = LW'($urandom); end
            full_drv = full_at(fmode, flo, fhi, c);
        end
        start = 1'b0;
        full_drv = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; full_drv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.sram_cen, bus.sram_wen, bus.l0_wr, bus.l0_rd, busy, done} !== 6'b110000) begin
            n_err++;
            $display("FAIL reset_ctrl cen,wen,wr,rd,busy,done got %b exp 110000",
                     {bus.sram_cen, bus.sram_wen, bus.l0_wr, bus.l0_rd, busy, done});
        end
        n_vec++;
        if (bus.sram_addr !== '0) begin
            n_err++; $display("FAIL reset_addr got %h exp 000", bus.sram_addr);
        end
        n_vec++;
        if (bus.l0_in !== '0) begin
            n_err++; $display("FAIL reset_l0_in got %h exp 0", bus.l0_in);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [AW-1:0] b;
        b = 11'h010;
        run_op(b, 7'd4, 0, 0, 0, 1'b0);
        n_vec++; if (o_timeout) begin n_err++; $display("FAIL basic_timeout got no done exp done"); end
        n_vec++; if (o_first_cen != 1) begin n_err++; $display("FAIL basic_first_cen got %0d exp 1", o_first_cen); end
        n_vec++; if (o_addr.size() != 4) begin n_err++; $display("FAIL basic_n_cen got %0d exp 4", o_addr.size()); end
        n_vec++; if (o_data.size() != 4) begin n_err++; $display("FAIL basic_n_wr got %0d exp 4", o_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < o_addr.size()) begin
                n_vec++;
                if (int'(o_addr[i]) != (int'(b) + i) % 2048) begin
                    n_err++; $display("FAIL basic_addr[%0d] got %h exp %h", i, o_addr[i], (int'(b) + i) % 2048);
                end
            end
            if (i < o_data.size()) begin
                n_vec++;
                if (o_data[i] !== mem[(int'(b) + i) % 2048]) begin
                    n_err++; $display("FAIL basic_data[%0d] got %h exp %h", i, o_data[i], mem[(int'(b) + i) % 2048]);
                end
            end
        end
        n_vec++; if (o_first_wr != 2 || o_last_wr != 5) begin
            n_err++; $display("FAIL basic_wr_window got %0d..%0d exp 2..5", o_first_wr, o_last_wr);
        end
        n_vec++; if (o_rd_n != 4 || o_first_rd != (OVL ? 3 : 6)) begin
            n_err++; $display("FAIL basic_rd got n=%0d first=%0d exp n=4 first=%0d", o_rd_n, o_first_rd, OVL ? 3 : 6);
        end
        n_vec++; if (o_done_cyc != (OVL ? 15 : 18)) begin
            n_err++; $display("FAIL basic_done_cycle got %0d exp %0d", o_done_cyc, OVL ? 15 : 18);
        end
        n_vec++; if (o_rd_rule != 0 || o_busy_bad != 0 || o_done_n != 1) begin
            n_err++; $display("FAIL basic_rd_busy_done got rd_bad=%0d busy_bad=%0d done_n=%0d exp 0,0,1",
                              o_rd_rule, o_busy_bad, o_done_n);
        end
    endtask

    task automatic test_stall();
        logic [AW-1:0] b;
        b = AW'($urandom);
        run_op(b, 7'd6, 1, 3, 5, 1'b0);
        n_vec++; if (o_timeout) begin n_err++; $display("FAIL stall_timeout got no done exp done"); end
        n_vec++; if (o_wr_full != 0) begin n_err++; $display("FAIL stall_wr_while_full got %0d exp 0", o_wr_full); end
        n_vec++; if (o_data.size() != 6) begin n_err++; $display("FAIL stall_n_wr got %0d exp 6", o_data.size()); end
        for (int i = 0; i < 6 && i < o_data.size(); i++) begin
            n_vec++;
            if (o_data[i] !== mem[(int'(b) + i) % 2048]) begin
                n_err++; $display("FAIL stall_data[%0d] got %h exp %h", i, o_data[i], mem[(int'(b) + i) % 2048]);
            end
        end
        n_vec++; if (o_rd_n != 6 || o_rd_rule != 0) begin
            n_err++; $display("FAIL stall_rd got n=%0d bad=%0d exp n=6 bad=0", o_rd_n, o_rd_rule);
        end
        n_vec++; if (o_done_cyc != o_last_rd + 1 + ROW) begin
            n_err++; $display("FAIL stall_wait got done=%0d exp %0d", o_done_cyc, o_last_rd + 1 + ROW);
        end
    endtask

    task automatic test_wrap();
        int exp_a [4] = '{'h7FE, 'h7FF, 'h000, 'h001};
        run_op(11'h7FE, 7'd4, 0, 0, 0, 1'b0);
        n_vec++; if (o_addr.size() != 4) begin n_err++; $display("FAIL wrap_n_cen got %0d exp 4", o_addr.size()); end
        for (int i = 0; i < 4 && i < o_addr.size(); i++) begin
            n_vec++;
            if (int'(o_addr[i]) != exp_a[i]) begin
                n_err++; $display("FAIL wrap_addr[%0d] got %h exp %h", i, o_addr[i], exp_a[i]);
            end
        end
        for (int i = 0; i < 4 && i < o_data.size(); i++) begin
            n_vec++;
            if (o_data[i] !== mem[exp_a[i]]) begin
                n_err++; $display("FAIL wrap_data[%0d] got %h exp %h", i, o_data[i], mem[exp_a[i]]);
            end
        end
        n_vec++; if (o_done_cyc != exp_done(4)) begin
            n_err++; $display("FAIL wrap_done_cycle got %0d exp %0d", o_done_cyc, exp_done(4));
        end
    endtask

    task automatic test_len0();
        run_op(AW'($urandom), 7'd0, 0, 0, 0, 1'b0);
        n_vec++; if (o_done_cyc != 1 || o_done_n != 1) begin
            n_err++; $display("FAIL len0_done got cyc=%0d n=%0d exp cyc=1 n=1", o_done_cyc, o_done_n);
        end
        n_vec++; if (o_addr.size() != 0 || o_data.size() != 0 || o_rd_n != 0) begin
            n_err++; $display("FAIL len0_activity got cen=%0d wr=%0d rd=%0d exp 0,0,0",
                              o_addr.size(), o_data.size(), o_rd_n);
        end
        n_vec++; if (o_busy_bad != 0) begin
            n_err++; $display("FAIL len0_busy got %0d bad cycles exp 0", o_busy_bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] b;
        int act;
        b = AW'($urandom);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = 7'd8;
        repeat (3) begin @(posedge clk); #1; start = 1'b0; end
        reset = 1'b1;                       // cycle 3
        @(posedge clk); #1;
        reset = 1'b0;                       // cycle 4
        @(negedge clk);
        n_vec++;
        if ({bus.sram_cen, bus.l0_wr, bus.l0_rd, busy, done} !== 5'b10000) begin
            n_err++; $display("FAIL midreset_ctrl cen,wr,rd,busy,done got %b exp 10000",
                              {bus.sram_cen, bus.l0_wr, bus.l0_rd, busy, done});
        end
        n_vec++; if (bus.sram_addr !== '0) begin
            n_err++; $display("FAIL midreset_addr got %h exp 000", bus.sram_addr);
        end
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.sram_cen !== 1'b1 || bus.l0_wr !== 1'b0 || bus.l0_rd !== 1'b0 || busy !== 1'b0) act++;
        end
        n_vec++; if (act != 0) begin n_err++; $display("FAIL midreset_idle got %0d active cycles exp 0", act); end
        b = AW'($urandom);
        run_op(b, 7'd8, 0, 0, 0, 1'b0);
        n_vec++; if (o_data.size() != 8) begin n_err++; $display("FAIL midreset_n_wr got %0d exp 8", o_data.size()); end
        for (int i = 0; i < 8 && i < o_data.size(); i++) begin
            n_vec++;
            if (o_data[i] !== mem[(int'(b) + i) % 2048]) begin
                n_err++; $display("FAIL midreset_data[%0d] got %h exp %h", i, o_data[i], mem[(int'(b) + i) % 2048]);
            end
        end
        n_vec++; if (o_done_cyc != exp_done(8)) begin
            n_err++; $display("FAIL midreset_done_cycle got %0d exp %0d", o_done_cyc, exp_done(8));
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        int n, pct, bad;
        for (int it = 0; it < 25; it++) begin
            b   = AW'($urandom);
            n   = $urandom_range(64, 1);
            pct = (it % 3 == 0) ? 0 : ((it % 3 == 1) ? 20 : 50);
            run_op(b, LW'(n), 2, pct, 0, 1'b1);
            n_vec++; if (o_timeout) begin n_err++; $display("FAIL rand%0d_timeout got no done exp done", it); end
            n_vec++; if (o_addr.size() != n || o_data.size() != n || o_rd_n != n) begin
                n_err++; $display("FAIL rand%0d_counts got cen=%0d wr=%0d rd=%0d exp %0d each",
                                  it, o_addr.size(), o_data.size(), o_rd_n, n);
            end
            bad = 0;
            for (int i = 0; i < o_addr.size(); i++)
                if (int'(o_addr[i]) != (int'(b) + i) % 2048) bad++;
            for (int i = 0; i < o_data.size(); i++)
                if (o_data[i] !== mem[(int'(b) + i) % 2048]) bad++;
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d_order got %0d wrong words exp 0", it, bad); end
            n_vec++; if (o_wr_full != 0 || o_rd_rule != 0 || o_busy_bad != 0 || o_done_n != 1) begin
                n_err++; $display("FAIL rand%0d_rules got wr_full=%0d rd_bad=%0d busy_bad=%0d done_n=%0d exp 0,0,0,1",
                                  it, o_wr_full, o_rd_rule, o_busy_bad, o_done_n);
            end
            n_vec++; if (o_done_cyc != o_last_rd + 1 + ROW) begin
                n_err++; $display("FAIL rand%0d_wait got done=%0d exp %0d", it, o_done_cyc, o_last_rd + 1 + ROW);
            end
            if (pct == 0) begin
                n_vec++; if (o_done_cyc != exp_done(n)) begin
                    n_err++; $display("FAIL rand%0d_done_cycle got %0d exp %0d", it, o_done_cyc, exp_done(n));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len0();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end
endmodule
